// File: rtl/lsu_if.sv
// Request and data-memory signals for the load/store unit, bundled as one port.
// The slave modport is the LSU's view; master is the requester/memory side.
interface lsu_if #(
  parameter int unsigned ADDR_WIDTH = 10
) ();
  logic                  start;
  logic                  is_load;
  logic                  is_store;
  logic [2:0]            funct3;
  logic [31:0]           addr;
  logic [31:0]           store_data;
  logic                  busy;
  logic                  done;
  logic                  err;
  logic [31:0]           load_data;
  logic                  mem_req;
  logic                  mem_we;
  logic [ADDR_WIDTH-3:0] mem_addr;
  logic [3:0]            mem_wstrb;
  logic [31:0]           mem_wdata;
  logic [31:0]           mem_rdata;
  logic                  mem_ack;

  modport slave (
    input  start, is_load, is_store, funct3, addr, store_data, mem_rdata, mem_ack,
    output busy, done, err, load_data, mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata
  );

  modport master (
    output start, is_load, is_store, funct3, addr, store_data, mem_rdata, mem_ack,
    input  busy, done, err, load_data, mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata
  );
endinterface

// File: rtl/lsu.sv
// RV32I load/store unit: checks alignment, issues one handshaked word access
// per request, and lane-extracts / extends load data.
module lsu #(
  parameter int unsigned ADDR_WIDTH = 10
) (
  input logic  clk,
  input logic  reset,
  lsu_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE, S_ERR} state_e;

  state_e                state_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  err_q;
  logic                  mem_req_q;
  logic                  mem_we_q;
  logic [ADDR_WIDTH-3:0] mem_addr_q;
  logic [3:0]            wstrb_q;
  logic [31:0]           wdata_q;
  logic [31:0]           load_data_q;
  logic [2:0]            funct3_q;
  logic [1:0]            off_q;

  logic                  legal_d;
  logic [3:0]            wstrb_d;
  logic [31:0]           wdata_d;
  logic [31:0]           lane_w;
  logic [31:0]           load_ext_d;
  logic                  unused_addr;

  // Address bits above the decoded range are deliberately ignored.
  assign unused_addr = ^bus.addr;

  always_comb begin
    legal_d = (bus.is_load != bus.is_store);
    case (bus.funct3)
      3'd0: ;
      3'd1: if (bus.addr[0]) legal_d = 1'b0;
      3'd2: if (bus.addr[1:0] != 2'b00) legal_d = 1'b0;
      3'd4: if (bus.is_store) legal_d = 1'b0;
      3'd5: if (bus.is_store || bus.addr[0]) legal_d = 1'b0;
      default: legal_d = 1'b0;
    endcase
  end

  always_comb begin
    wstrb_d = '0;
    wdata_d = bus.store_data;
    case (bus.funct3[1:0])
      2'd0: begin
        wstrb_d = 4'b0001 << bus.addr[1:0];
        wdata_d = {4{bus.store_data[7:0]}};
      end
      2'd1: begin
        wstrb_d = 4'b0011 << bus.addr[1:0];
        wdata_d = {2{bus.store_data[15:0]}};
      end
      default: begin
        wstrb_d = 4'b1111;
        wdata_d = bus.store_data;
      end
    endcase
    if (!bus.is_store) wstrb_d = '0;
  end

  // Byte offset of the access shifts the addressed lane down to bit 0.
  always_comb begin
    lane_w     = bus.mem_rdata >> {off_q, 3'b000};
    load_ext_d = lane_w;
    case (funct3_q)
      3'd0:    load_ext_d = {{24{lane_w[7]}}, lane_w[7:0]};
      3'd1:    load_ext_d = {{16{lane_w[15]}}, lane_w[15:0]};
      3'd4:    load_ext_d = {24'h000000, lane_w[7:0]};
      3'd5:    load_ext_d = {16'h0000, lane_w[15:0]};
      default: load_ext_d = lane_w;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      wstrb_q     <= '0;
      wdata_q     <= '0;
      load_data_q <= '0;
      funct3_q    <= '0;
      off_q       <= '0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            busy_q   <= 1'b1;
            funct3_q <= bus.funct3;
            off_q    <= bus.addr[1:0];
            if (legal_d) begin
              state_q    <= S_REQ;
              mem_req_q  <= 1'b1;
              mem_we_q   <= bus.is_store;
              mem_addr_q <= bus.addr[ADDR_WIDTH-1:2];
              wstrb_q    <= wstrb_d;
              wdata_q    <= wdata_d;
            end else begin
              state_q <= S_ERR;
              done_q  <= 1'b1;
              err_q   <= 1'b1;
            end
          end
        end
        S_REQ: begin
          if (bus.mem_ack) begin
            state_q   <= S_DONE;
            done_q    <= 1'b1;
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
            if (!mem_we_q) load_data_q <= load_ext_d;
          end
        end
        S_DONE, S_ERR: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.load_data = load_data_q;
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wstrb = wstrb_q;
  assign bus.mem_wdata = wdata_q;

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu: a transaction-level model sets per-cycle expectations,
// one negedge process compares them against the DUT outputs.
module tb_lsu;
  localparam int unsigned AW = 10;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  lsu_if #(.ADDR_WIDTH(AW)) bus ();
  lsu #(.ADDR_WIDTH(AW)) dut (.clk(clk), .reset(reset), .bus(bus));

  int n_vec = 0;
  int n_mis = 0;

  bit          chk_en = 1'b0;
  logic        exp_busy, exp_done, exp_err, exp_req, exp_we, exp_chkwd;
  logic [31:0] exp_addr, exp_strb, exp_wdata, exp_ld;
  logic [31:0] model_ld;

  typedef struct {
    bit          ld, st;
    logic [2:0]  f3;
    logic [31:0] addr, sd, rd;
    int unsigned waits;
    int          rst_at;
    bit          decoy;
    bit          lit;
    logic [31:0] l_addr, l_strb, l_wd, l_ld;
  } txn_t;

  txn_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", 32'(bus.busy), 32'(exp_busy));
      chk("done", 32'(bus.done), 32'(exp_done));
      chk("err", 32'(bus.err), 32'(exp_err));
      chk("mem_req", 32'(bus.mem_req), 32'(exp_req));
      chk("load_data", bus.load_data, exp_ld);
      if (exp_req) begin
        chk("mem_we", 32'(bus.mem_we), 32'(exp_we));
        chk("mem_addr", 32'(bus.mem_addr), exp_addr);
        chk("mem_wstrb", 32'(bus.mem_wstrb), exp_strb);
        if (exp_chkwd) chk("mem_wdata", bus.mem_wdata, exp_wdata);
      end
    end
  end

  function automatic int unsigned m_size(input logic [2:0] f3);
    return (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
  endfunction

  function automatic bit m_legal(input txn_t t);
    int unsigned sz = m_size(t.f3);
    if (t.ld == t.st) return 0;
    if (t.st && !(t.f3 inside {3'd0, 3'd1, 3'd2})) return 0;
    if (t.ld && !(t.f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) return 0;
    return (t.addr % sz) == 0;
  endfunction

  function automatic logic [31:0] m_strb(input txn_t t);
    int unsigned sz = m_size(t.f3);
    int unsigned off = t.addr % 4;
    logic [31:0] s = 0;
    if (!t.st) return 0;
    for (int unsigned i = 0; i < 4; i++)
      if (i >= off && i < off + sz) s = s | (32'd1 << i);
    return s;
  endfunction

  function automatic logic [31:0] m_wdata(input txn_t t);
    int unsigned sz = m_size(t.f3);
    logic [31:0] w = 0;
    for (int unsigned i = 0; i < 4; i++)
      w = w | (((t.sd >> (8 * (i % sz))) & 32'hFF) << (8 * i));
    return w;
  endfunction

  function automatic logic [31:0] m_load(input txn_t t);
    int unsigned sz = m_size(t.f3);
    logic [31:0] mask = (sz == 4) ? 32'hFFFFFFFF : ((32'd1 << (8 * sz)) - 1);
    logic [31:0] v = (t.rd >> (8 * (t.addr % 4))) & mask;
    if (t.f3 < 3'd4 && sz < 4 && v[8*sz-1]) v = v | ~mask;
    return v;
  endfunction

  function automatic txn_t mk(input bit ld, input bit st, input logic [2:0] f3,
                              input logic [31:0] addr, input logic [31:0] sd,
                              input logic [31:0] rd, input int unsigned waits,
                              input int rst_at, input bit decoy);
    txn_t t;
    t.ld = ld; t.st = st; t.f3 = f3; t.addr = addr; t.sd = sd; t.rd = rd;
    t.waits = waits; t.rst_at = rst_at; t.decoy = decoy; t.lit = 1'b0;
    t.l_addr = 0; t.l_strb = 0; t.l_wd = 0; t.l_ld = 0;
    return t;
  endfunction

  function automatic txn_t lit(input txn_t t, input logic [31:0] a, input logic [31:0] s,
                               input logic [31:0] wd, input logic [31:0] ldv);
    txn_t r = t;
    r.lit = 1'b1; r.l_addr = a; r.l_strb = s; r.l_wd = wd; r.l_ld = ldv;
    return r;
  endfunction

  task automatic set_idle_exp();
    exp_busy = 0; exp_done = 0; exp_err = 0; exp_req = 0; exp_we = 0;
    exp_chkwd = 0; exp_ld = model_ld;
  endtask

  task automatic drive_decoy();
    bus.start = 1'b1; bus.is_load = 1'b1; bus.is_store = 1'b0;
    bus.funct3 = 3'd2; bus.addr = 32'h0;
  endtask

  task automatic run(input txn_t t);
    bit legal = m_legal(t);
    bus.start = 1'b1; bus.is_load = t.ld; bus.is_store = t.st; bus.funct3 = t.f3;
    bus.addr = t.addr; bus.store_data = t.sd; bus.mem_ack = t.decoy;
    set_idle_exp();
    @(posedge clk); #1;
    bus.start = 1'b0; bus.addr = $urandom; bus.store_data = $urandom;
    bus.funct3 = 3'($urandom); bus.mem_ack = 1'b0;
    if (!legal) begin
      exp_busy = 1; exp_done = 1; exp_err = 1; exp_req = 0;
      if (t.lit) chk("lit_err_load_data", bus.load_data, t.l_ld);
      if (t.decoy) drive_decoy();
      @(posedge clk); #1;
      set_idle_exp();
      return;
    end
    exp_busy = 1; exp_done = 0; exp_err = 0; exp_req = 1; exp_we = t.st;
    exp_addr = (t.addr % (1 << AW)) >> 2; exp_strb = m_strb(t);
    exp_wdata = m_wdata(t); exp_chkwd = t.st;
    for (int unsigned w = 0; w <= t.waits; w++) begin
      if (t.lit && w == 0) begin
        chk("lit_mem_addr", 32'(bus.mem_addr), t.l_addr);
        chk("lit_mem_wstrb", 32'(bus.mem_wstrb), t.l_strb);
        if (t.st) chk("lit_mem_wdata", bus.mem_wdata, t.l_wd);
      end
      bus.mem_ack = (w == t.waits);
      bus.mem_rdata = (w == t.waits) ? t.rd : $urandom;
      if (t.decoy && w == 1) drive_decoy(); else bus.start = 1'b0;
      if (t.rst_at == int'(w)) begin
        bus.mem_ack = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        model_ld = 0;
        set_idle_exp();
        return;
      end
      @(posedge clk); #1;
    end
    bus.mem_ack = 1'b0; bus.mem_rdata = $urandom; bus.start = 1'b0;
    if (t.ld) model_ld = m_load(t);
    exp_busy = 1; exp_done = 1; exp_err = 0; exp_req = 0; exp_ld = model_ld;
    if (t.lit && t.ld) chk("lit_load_data", bus.load_data, t.l_ld);
    if (t.decoy) drive_decoy();
    @(posedge clk); #1;
    set_idle_exp();
  endtask

  initial begin
    reset = 1'b1;
    bus.start = 0; bus.is_load = 0; bus.is_store = 0; bus.funct3 = 0;
    bus.addr = 0; bus.store_data = 0; bus.mem_rdata = 0; bus.mem_ack = 0;
    model_ld = 0;
    repeat (2) @(posedge clk);
    #1;
    set_idle_exp();
    exp_addr = 0; exp_strb = 0; exp_wdata = 0;
    chk_en = 1'b1;
    chk("reset_mem_addr", 32'(bus.mem_addr), 32'h0);
    chk("reset_mem_wstrb", 32'(bus.mem_wstrb), 32'h0);
    chk("reset_mem_wdata", bus.mem_wdata, 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;

    vecs.push_back(lit(mk(1, 0, 3'd2, 32'h104, 32'h0, 32'hDEADBEEF, 0, -1, 0),
                       32'h41, 32'h0, 32'h0, 32'hDEADBEEF));
    vecs.push_back(lit(mk(1, 0, 3'd0, 32'h007, 32'h0, 32'h80123456, 0, -1, 0),
                       32'h1, 32'h0, 32'h0, 32'hFFFFFF80));
    vecs.push_back(lit(mk(1, 0, 3'd4, 32'h007, 32'h0, 32'h80123456, 0, -1, 0),
                       32'h1, 32'h0, 32'h0, 32'h00000080));
    vecs.push_back(lit(mk(1, 0, 3'd1, 32'h006, 32'h0, 32'h80015A5A, 0, -1, 0),
                       32'h1, 32'h0, 32'h0, 32'hFFFF8001));
    vecs.push_back(lit(mk(0, 1, 3'd1, 32'h00A, 32'h1234ABCD, 32'h0, 1, -1, 0),
                       32'h2, 32'hC, 32'hABCDABCD, 32'h0));
    vecs.push_back(lit(mk(1, 0, 3'd2, 32'h102, 32'h0, 32'h0, 0, -1, 1),
                       32'h0, 32'h0, 32'h0, 32'hFFFF8001));
    vecs.push_back(lit(mk(1, 1, 3'd2, 32'h100, 32'h0, 32'h0, 0, -1, 0),
                       32'h0, 32'h0, 32'h0, 32'hFFFF8001));
    vecs.push_back(lit(mk(0, 1, 3'd0, 32'hFFFFF3FD, 32'h000000A5, 32'h0, 3, -1, 1),
                       32'hFF, 32'h2, 32'hA5A5A5A5, 32'h0));
    vecs.push_back(lit(mk(1, 0, 3'd5, 32'h002, 32'h0, 32'h9ABC1234, 3, -1, 1),
                       32'h0, 32'h0, 32'h0, 32'h00009ABC));
    vecs.push_back(lit(mk(0, 1, 3'd2, 32'h010, 32'hCAFEF00D, 32'h0, 0, -1, 0),
                       32'h4, 32'hF, 32'hCAFEF00D, 32'h0));
    vecs.push_back(mk(1, 0, 3'd1, 32'h003, 32'h0, 32'h0, 0, -1, 0));
    vecs.push_back(mk(0, 1, 3'd4, 32'h000, 32'h11, 32'h0, 0, -1, 0));
    vecs.push_back(mk(1, 0, 3'd3, 32'h000, 32'h0, 32'h0, 0, -1, 0));
    vecs.push_back(mk(0, 0, 3'd2, 32'h000, 32'h0, 32'h0, 0, -1, 0));
    vecs.push_back(mk(1, 0, 3'd0, 32'h003, 32'h0, 32'h7F00AA55, 2, -1, 0));
    vecs.push_back(mk(1, 0, 3'd2, 32'h020, 32'h0, 32'h0, 3, 1, 0));
    vecs.push_back(lit(mk(1, 0, 3'd2, 32'h024, 32'h0, 32'h13579BDF, 0, -1, 0),
                       32'h9, 32'h0, 32'h0, 32'h13579BDF));
    vecs.push_back(mk(0, 1, 3'd1, 32'h3FE, 32'hFFFF8765, 32'h0, 2, -1, 0));
    vecs.push_back(mk(1, 0, 3'd1, 32'h000, 32'h0, 32'h12347FFF, 0, -1, 0));

    foreach (vecs[i]) run(vecs[i]);
    bus.start = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk_en = 1'b0;
    chk("final_load_data", bus.load_data, 32'h00007FFF);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end
endmodule
